// File: rtl/stencil_pkg.sv
// Shared types, default sizes and packing helpers for the stencil window generator.
package stencil_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int DEF_BW      = 32;
  localparam int DEF_ST      = 3;
  localparam int DEF_COLUMNS = 6;

  // Width of a column index: $clog2(columns), but never narrower than 1 bit.
  function automatic int calc_cw(input int columns);
    int w;
    w = $clog2(columns);
    return (w < 1) ? 1 : w;
  endfunction

  // Bit offset of word k of window column j in the packed window.
  function automatic int win_idx(input int j, input int k, input int st, input int bw);
    return (j * st + k) * bw;
  endfunction

endpackage

// File: rtl/stencil_col_shift.sv
// ST-deep column shift register holding one stencil window. A new column
// enters at j=ST-1 and column 0 falls out. o_next_window exposes the
// post-shift window so the caller can capture it in the same cycle.
module stencil_col_shift
  import stencil_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int ST = DEF_ST
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_shift,
  input  logic                i_zero,
  input  logic                i_clear,
  input  logic [BW*ST-1:0]    i_col,
  output logic [BW*ST*ST-1:0] o_next_window
);

  localparam int COL_W = BW * ST;

  logic [BW*ST*ST-1:0] r_window;
  logic [BW*ST*ST-1:0] w_shifted;
  logic [COL_W-1:0]    w_in_col;

  assign w_in_col = i_zero ? '0 : i_col;

  // Every column moves one slot towards j=0.
  for (genvar j = 0; j < ST - 1; j++) begin : g_move
    assign w_shifted[win_idx(j, 0, ST, BW) +: COL_W] = r_window[win_idx(j + 1, 0, ST, BW) +: COL_W];
  end
  assign w_shifted[win_idx(ST - 1, 0, ST, BW) +: COL_W] = w_in_col;

  assign o_next_window = w_shifted;

  // Window storage: clear wins over shift, so a flush can end on an empty window.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_window <= '0;
    end else if (i_clear) begin
      r_window <= '0;
    end else if (i_shift) begin
      r_window <= w_shifted;
    end
  end

endmodule

// File: rtl/stencil_window_gen.sv
// Sliding-window generator: accepts ST-word columns and emits full ST x ST
// windows through a single registered output slot with backpressure.
// PAD_MODE=1 adds zero-padded edge windows via a short FLUSH phase per row.
module stencil_window_gen
  import stencil_pkg::*;
#(
  parameter int BW       = DEF_BW,
  parameter int ST       = DEF_ST,
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int PAD_MODE = 0,
  localparam int CW      = calc_cw(COLUMNS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [BW*ST-1:0]    io_in_data,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [BW*ST*ST-1:0] io_out_data,
  output logic [CW-1:0]       io_out_col,
  output logic                io_out_last
);

  localparam int H   = (ST - 1) / 2;
  localparam int HM1 = (H > 0) ? H - 1 : 0;
  localparam bit DO_FLUSH = (PAD_MODE != 0) && (H > 0);

  // First column of a row whose acceptance yields a window.
  localparam logic [CW-1:0] L_FIRST       = CW'((PAD_MODE != 0) ? H : ST - 1);
  localparam logic [CW-1:0] L_H           = CW'(H);
  localparam logic [CW-1:0] L_HM1         = CW'(HM1);
  localparam logic [CW-1:0] L_LAST_COL    = CW'(COLUMNS - 1);
  localparam logic [CW-1:0] L_FLUSH_BASE  = CW'(COLUMNS - H);
  localparam logic [CW-1:0] L_LAST_CENTRE = CW'((PAD_MODE != 0) ? COLUMNS - 1 : COLUMNS - 1 - H);

  state_t              r_state;
  logic [CW-1:0]       r_col;
  logic [CW-1:0]       r_flush_cnt;
  logic                r_out_valid;
  logic [BW*ST*ST-1:0] r_out_data;
  logic [CW-1:0]       r_out_col;
  logic                r_out_last;

  logic                w_can_produce;
  logic                w_accept;
  logic                w_flush_step;
  logic                w_flush_done;
  logic                w_run_emit;
  logic                w_produce;
  logic [CW-1:0]       w_centre;
  logic [BW*ST*ST-1:0] w_next_window;

  // The slot can take a new window if it is empty or being drained this cycle.
  assign w_can_produce = !r_out_valid || io_out_ready;
  assign io_in_ready   = (r_state == RUN) && w_can_produce;
  assign w_accept      = io_in_valid && io_in_ready;
  assign w_flush_step  = (r_state == FLUSH) && w_can_produce;
  assign w_flush_done  = w_flush_step && (r_flush_cnt == L_HM1);
  assign w_run_emit    = w_accept && (r_col >= L_FIRST);
  assign w_produce     = w_run_emit || w_flush_step;
  assign w_centre      = (r_state == FLUSH) ? (L_FLUSH_BASE + r_flush_cnt) : (r_col - L_H);

  stencil_col_shift #(
    .BW (BW),
    .ST (ST)
  ) u_col_shift (
    .clock         (clock),
    .reset         (reset),
    .i_shift       (w_accept || w_flush_step),
    .i_zero        (r_state == FLUSH),
    .i_clear       (w_flush_done),
    .i_col         (io_in_data),
    .o_next_window (w_next_window)
  );

  // Row/flush sequencing plus the registered output slot.
  // NOTE: the output data register is reset as well, because the outputs must read zero during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_col       <= '0;
      r_flush_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept) begin
            if (r_col == L_LAST_COL) begin
              r_col <= '0;
              if (DO_FLUSH) begin
                r_state     <= FLUSH;
                r_flush_cnt <= '0;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (w_flush_step) begin
            if (w_flush_done) begin
              r_state <= RUN;
            end else begin
              r_flush_cnt <= r_flush_cnt + 1'b1;
            end
          end
        end
        default: r_state <= RUN;
      endcase

      // A produce overrides a concurrent fire, so back-to-back windows leave no bubble.
      if (w_produce) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_next_window;
        r_out_col   <= w_centre;
        r_out_last  <= (w_centre == L_LAST_CENTRE);
      end else if (io_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_out_valid = r_out_valid;
  assign io_out_data  = r_out_data;
  assign io_out_col   = r_out_col;
  assign io_out_last  = r_out_last;

endmodule
